serial_frame_controller: RTL and testbench

- Control FSM directly upstream of the 4-bit NumData shift register and the port-number shift register in the serial receive path.
- Watches the serial line for a start bit, then generates the shift enables for the port field (sh_enP) and the data-count field (sh_enD).
- Reads back the assembled NumData to count the payload bits, then flags frame completion.
- Frame format on SerIn, one bit per enabled clock: start bit (0), PORT_BITS port bits, NUM_BITS count bits MSB first, then NumData payload bits.

---
 rtl/serial_frame_controller_if.sv | 23 ++
 rtl/serial_frame_controller.sv | 104 ++++++++++
 tb/tb_serial_frame_controller.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_controller_if.sv
// rtl/serial_frame_controller_if.sv - serial line, count read-back and shift-enable bundle for the frame controller
interface serial_frame_controller_if #(
    parameter int NUM_BITS = 4
);
    logic                clkEN;
    logic                SerIn;
    logic [NUM_BITS-1:0] NumData;
    logic                sh_enP;
    logic                sh_enD;
    logic                data_valid;
    logic                done;
    logic                busy;

    modport master (
        output clkEN, SerIn, NumData,
        input  sh_enP, sh_enD, data_valid, done, busy
    );

    modport slave (
        input  clkEN, SerIn, NumData,
        output sh_enP, sh_enD, data_valid, done, busy
    );
endinterface

// File: rtl/serial_frame_controller.sv
// rtl/serial_frame_controller.sv - start-bit detect and port/count/payload sequencing FSM for the serial receive path
module serial_frame_controller #(
    parameter int PORT_BITS = 2,
    parameter int NUM_BITS  = 4,
    parameter int CNT_W     = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    serial_frame_controller_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PORT = 3'd1,
        S_NUM  = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PORT_LAST = CNT_W'(PORT_BITS - 1);
    localparam logic [CNT_W-1:0] NUM_LAST  = CNT_W'(NUM_BITS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_num_ext;
    logic [CNT_W-1:0] w_data_last;
    logic             w_num_zero;

    assign w_num_ext   = CNT_W'(bus.NumData);
    assign w_data_last = w_num_ext - CNT_W'(1);
    assign w_num_zero  = (bus.NumData == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.clkEN && !bus.SerIn) begin
                    w_next     = S_PORT;
                    w_cnt_next = '0;
                end
            end
            S_PORT: begin
                if (bus.clkEN) begin
                    if (r_cnt == PORT_LAST) begin
                        w_next     = S_NUM;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_NUM: begin
                if (bus.clkEN) begin
                    if (r_cnt == NUM_LAST) begin
                        w_next     = S_DATA;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                // An empty payload still spends one slot here so done always follows DATA
                if (bus.clkEN) begin
                    if (w_num_zero || r_cnt == w_data_last) begin
                        w_next     = S_DONE;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (bus.clkEN) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    assign bus.sh_enP     = (r_state == S_PORT);
    assign bus.sh_enD     = (r_state == S_NUM);
    assign bus.data_valid = (r_state == S_DATA) && !w_num_zero;
    assign bus.done       = (r_state == S_DONE);
    assign bus.busy       = (r_state == S_PORT) || (r_state == S_NUM) ||
                            (r_state == S_DATA) || (r_state == S_DONE);
endmodule

// File: tb/tb_serial_frame_controller.sv
// tb/tb_serial_frame_controller.sv - randomized bench for serial_frame_controller against a frame-parsing model
module tb_serial_frame_controller;
    localparam int P = 2;
    localparam int N = 4;

    logic clock;
    logic reset;

    serial_frame_controller_if #(.NUM_BITS(N)) bus();

    serial_frame_controller #(.PORT_BITS(P), .NUM_BITS(N), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int n_shp, n_shd, n_dv, n_done, n_busy;

    bit         q_bits[$];
    logic [4:0] q_exp[$];
    logic [3:0] q_num[$];

    // expected vector order: {busy, done, data_valid, sh_enD, sh_enP}
    function automatic logic [4:0] observed();
        return {bus.busy, bus.done, bus.data_valid, bus.sh_enD, bus.sh_enP};
    endfunction

    task automatic add_idle(input int k);
        for (int i = 0; i < k; i++) q_bits.push_back(1'b1);
    endtask

    task automatic add_frame(input int port, input int n);
        int dlen;
        dlen = (n == 0) ? 1 : n;
        q_bits.push_back(1'b0);
        for (int i = P - 1; i >= 0; i--) q_bits.push_back(bit'((port >> i) & 1));
        for (int i = N - 1; i >= 0; i--) q_bits.push_back(bit'((n >> i) & 1));
        for (int i = 0; i < dlen; i++) q_bits.push_back(bit'($urandom_range(1, 0)));
        q_bits.push_back(bit'($urandom_range(1, 0)));
    endtask

    // Parses the bit stream slot by slot into the expected output vector of each slot
    function automatic void build();
        int pos;
        int sz;
        int n;
        int dlen;
        q_exp.delete();
        q_num.delete();
        pos = 0;
        sz  = q_bits.size();
        while (pos < sz) begin
            if (q_bits[pos]) begin
                q_exp.push_back(5'b00000);
                q_num.push_back(4'($urandom));
                pos++;
            end else begin
                q_exp.push_back(5'b00000);
                q_num.push_back(4'($urandom));
                pos++;
                for (int i = 0; i < P; i++) begin
                    q_exp.push_back(5'b10001);
                    q_num.push_back(4'($urandom));
                end
                pos += P;
                n = 0;
                for (int i = 0; i < N; i++)
                    n = (n << 1) | ((pos + i < sz) ? int'(q_bits[pos + i]) : 0);
                for (int i = 0; i < N; i++) begin
                    q_exp.push_back(5'b10010);
                    q_num.push_back(4'(n));
                end
                pos += N;
                dlen = (n == 0) ? 1 : n;
                for (int i = 0; i < dlen; i++) begin
                    q_exp.push_back({1'b1, 1'b0, (n != 0), 2'b00});
                    q_num.push_back(4'(n));
                end
                q_exp.push_back(5'b11000);
                q_num.push_back(4'(n));
                pos += dlen + 1;
            end
        end
    endfunction

    task automatic run_stream(input string name, input int gmin, input int gmax, input int nslots);
        int per;
        logic [4:0] obs;
        n_shp = 0; n_shd = 0; n_dv = 0; n_done = 0; n_busy = 0;
        for (int k = 0; k < nslots; k++) begin
            per = $urandom_range(gmax, gmin);
            for (int c = 0; c < per; c++) begin
                @(negedge clock);
                obs = observed();
                checks++;
                if (obs !== q_exp[k]) begin
                    errors++;
                    if (errors < 40)
                        $display("FAIL %s slot %0d clk %0d outputs got %b want %b", name, k, c, obs, q_exp[k]);
                end
                if (c == 0) begin
                    n_shp  += int'(obs[0]);
                    n_shd  += int'(obs[1]);
                    n_dv   += int'(obs[2]);
                    n_done += int'(obs[3]);
                    n_busy += int'(obs[4]);
                end
                bus.SerIn   = q_bits[k];
                bus.NumData = q_num[k];
                bus.clkEN   = (c == per - 1);
            end
        end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.clkEN = 1'b1;
        bus.SerIn = 1'b0;
        bus.NumData = 4'hF;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (observed() !== 5'b00000) begin
                errors++;
                $display("FAIL reset_outputs got %b want 00000", observed());
            end
        end
        bus.SerIn = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (observed() !== 5'b00000) begin
            errors++;
            $display("FAIL reset_release got %b want 00000", observed());
        end
    endtask

    task automatic test_basic();
        q_bits.delete();
        q_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        add_idle(4);
        build();
        run_stream("basic", 1, 1, q_bits.size());
        expect_int("basic_shp", n_shp, 2);
        expect_int("basic_shd", n_shd, 4);
        expect_int("basic_dv", n_dv, 3);
        expect_int("basic_done", n_done, 1);
    endtask

    task automatic test_enable_gating();
        q_bits.delete();
        q_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        add_idle(3);
        build();
        run_stream("gating", 4, 4, q_bits.size());
        expect_int("gating_dv", n_dv, 3);
        expect_int("gating_done", n_done, 1);
        q_bits.delete();
        add_idle(2);
        add_frame($urandom_range(3, 0), $urandom_range(15, 1));
        add_idle(2);
        build();
        run_stream("gating_rand", 1, 5, q_bits.size());
    endtask

    task automatic test_zero_len();
        q_bits.delete();
        add_frame($urandom_range(3, 0), 0);
        add_idle(3);
        build();
        run_stream("zero_len", 1, 2, q_bits.size());
        expect_int("zero_dv", n_dv, 0);
        expect_int("zero_done", n_done, 1);
        expect_int("zero_busy", n_busy, P + N + 1 + 1);
    endtask

    task automatic test_max_len();
        q_bits.delete();
        add_frame($urandom_range(3, 0), 15);
        add_idle(3);
        build();
        run_stream("max_len", 1, 1, q_bits.size());
        expect_int("max_dv", n_dv, 15);
        expect_int("max_frame_len", n_busy + 1, 23);
    endtask

    task automatic test_reset_mid_num();
        q_bits.delete();
        add_frame($urandom_range(3, 0), $urandom_range(15, 0));
        build();
        run_stream("pre_reset", 1, 1, 1 + P + 2);
        @(negedge clock);
        checks++;
        if (observed() !== 5'b10010) begin
            errors++;
            $display("FAIL mid_num_state got %b want 10010", observed());
        end
        bus.clkEN = 1'b0;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (observed() !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset got %b want 00000", observed());
        end
        @(negedge clock);
        reset = 1'b1;
        bus.SerIn = 1'b1;
        bus.clkEN = 1'b1;
        q_bits.delete();
        add_idle(3);
        add_frame($urandom_range(3, 0), 5);
        add_idle(2);
        build();
        run_stream("post_reset", 1, 3, q_bits.size());
        expect_int("post_reset_dv", n_dv, 5);
    endtask

    task automatic test_back_to_back();
        q_bits.delete();
        add_idle(20);
        add_frame($urandom_range(3, 0), 2);
        add_frame($urandom_range(3, 0), 1);
        add_idle(3);
        build();
        run_stream("back_to_back", 1, 1, q_bits.size());
        expect_int("b2b_done", n_done, 2);
        expect_int("b2b_dv", n_dv, 3);
        expect_int("b2b_busy", n_busy, 2 * (P + N + 1) + 2 + 1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            q_bits.delete();
            add_idle($urandom_range(3, 0));
            for (int f = 0; f < 3; f++) begin
                add_frame($urandom_range(3, 0), $urandom_range(15, 0));
                add_idle($urandom_range(2, 0));
            end
            add_idle(2);
            build();
            run_stream("random", 1, 3, q_bits.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_enable_gating();
        test_zero_len();
        test_max_len();
        test_reset_mid_num();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
